// File: rtl/seq_signed_multiplier_if.sv
// Start/ready/done handshake bundle for the iterative multiplier.
// Operands and controls go from the master to the slave; status and product come back from the slave.
interface seq_signed_multiplier_if #(
   parameter int unsigned WIDTH_P = 32
);
   logic [WIDTH_P-1:0]   multiplicand_i;
   logic [WIDTH_P-1:0]   multiplier_i;
   logic                 a_signed_i;
   logic                 b_signed_i;
   logic                 start_i;
   logic                 flush_i;
   logic                 ready_o;
   logic                 done_o;
   logic [2*WIDTH_P-1:0] product_o;

   modport master (
      output multiplicand_i, multiplier_i, a_signed_i, b_signed_i, start_i, flush_i,
      input  ready_o, done_o, product_o
   );

   modport slave (
      input  multiplicand_i, multiplier_i, a_signed_i, b_signed_i, start_i, flush_i,
      output ready_o, done_o, product_o
   );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Iterative shift-add multiplier on operand magnitudes, followed by one sign fix-up cycle.
// Define MULT_EARLY_TERM_EN to let CALC stop as soon as the remaining multiplier bits are zero.
module seq_signed_multiplier #(
   parameter int unsigned WIDTH_P = 32
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   seq_signed_multiplier_if.slave bus
);
   localparam int unsigned CNT_W_P  = $clog2(WIDTH_P);
   localparam int unsigned PROD_W_P = 2 * WIDTH_P;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e               state_q, state_d;
   logic [PROD_W_P-1:0]  mcand_q, mcand_d;
   logic [WIDTH_P-1:0]   mplr_q,  mplr_d;
   logic [PROD_W_P-1:0]  acc_q,   acc_d;
   logic [CNT_W_P-1:0]   cnt_q,   cnt_d;
   logic                 neg_q,   neg_d;
   logic                 ready_q, ready_d;
   logic                 done_q,  done_d;
   logic [PROD_W_P-1:0]  product_q, product_d;

   logic                 a_neg_c, b_neg_c;
   logic [WIDTH_P-1:0]   abs_a_c, abs_b_c;
   logic                 last_iter_c;

   // Magnitudes of the incoming operands; |most-negative| still fits in WIDTH_P unsigned bits.
   always_comb begin
      a_neg_c = bus.a_signed_i & bus.multiplicand_i[WIDTH_P-1];
      b_neg_c = bus.b_signed_i & bus.multiplier_i[WIDTH_P-1];
      abs_a_c = a_neg_c ? -bus.multiplicand_i : bus.multiplicand_i;
      abs_b_c = b_neg_c ? -bus.multiplier_i   : bus.multiplier_i;
   end

`ifdef MULT_EARLY_TERM_EN
   assign last_iter_c = (cnt_q == CNT_W_P'(WIDTH_P - 1)) || (mplr_q[WIDTH_P-1:1] == '0);
`else
   assign last_iter_c = (cnt_q == CNT_W_P'(WIDTH_P - 1));
`endif

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      done_d    = 1'b0;
      product_d = product_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
               mcand_d = {WIDTH_P'(0), abs_a_c};
               mplr_d  = abs_b_c;
               acc_d   = '0;
               cnt_d   = '0;
               neg_d   = a_neg_c ^ b_neg_c;
               state_d = CALC;
            end
         end
         CALC: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else begin
               if (mplr_q[0]) acc_d = acc_q + mcand_q;
               mcand_d = mcand_q << 1;
               mplr_d  = mplr_q >> 1;
               cnt_d   = cnt_q + CNT_W_P'(1);
               if (last_iter_c) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!bus.flush_i) begin
               product_d = neg_q ? -acc_q : acc_q;
               done_d    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign bus.ready_o   = ready_q;
   assign bus.done_o    = done_q;
   assign bus.product_o = product_q;
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier at WIDTH_P=8: vector table, corner sequences, random ops.
module tb_seq_signed_multiplier;
   localparam int unsigned W = 8;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   seq_signed_multiplier_if #(.WIDTH_P(W)) bus ();

   seq_signed_multiplier #(.WIDTH_P(W)) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        as;
      logic        bs;
      logic [15:0] prod;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: interpret operands as integers, multiply, keep the low 16 bits.
   function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs);
      int va;
      int vb;
      va = (as && a[7]) ? int'(a) - 256 : int'(a);
      vb = (bs && b[7]) ? int'(b) - 256 : int'(b);
      return 16'(va * vb);
   endfunction

   function automatic int exp_latency(input logic [7:0] b, input logic bs);
`ifdef MULT_EARLY_TERM_EN
      int mag;
      int k;
      mag = (bs && b[7]) ? 256 - int'(b) : int'(b);
      k = 0;
      while ((mag >> k) != 0) k++;
      return ((k < 1) ? 1 : k) + 1;
`else
      return int'(W) + 1;
`endif
   endfunction

   // Issue one op; lat = edges from the accepting edge until done_o is seen.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic as, input logic bs,
                         output logic [15:0] prod, output int lat);
      @(negedge clk);
      bus.multiplicand_i = a;
      bus.multiplier_i   = b;
      bus.a_signed_i     = as;
      bus.b_signed_i     = bs;
      bus.start_i        = 1'b1;
      @(posedge clk); #1;
      bus.start_i        = 1'b0;
      bus.multiplicand_i = 8'($urandom);
      bus.multiplier_i   = 8'($urandom);
      bus.a_signed_i     = 1'($urandom);
      bus.b_signed_i     = 1'($urandom);
      check("accept_ready", 64'(bus.ready_o), 64'(0));
      check("accept_done", 64'(bus.done_o), 64'(0));
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.done_o && lat < 40);
      if (!bus.done_o) check("done_timeout", 64'(bus.done_o), 64'(1));
      check("done_ready", 64'(bus.ready_o), 64'(1));
      prod = bus.product_o;
   endtask

   vec_t        vecs[8];
   logic [15:0] p;
   logic [15:0] held;
   int          lat;
   logic [7:0]  ra;
   logic [7:0]  rb;
   logic        ras;
   logic        rbs;
   bit          saw_done;

   initial begin
      tests = 0;
      fails = 0;
      bus.multiplicand_i = '0;
      bus.multiplier_i   = '0;
      bus.a_signed_i     = 1'b0;
      bus.b_signed_i     = 1'b0;
      bus.start_i        = 1'b0;
      bus.flush_i        = 1'b0;
      rst_n = 1'b0;
      #12;
      check("reset_ready", 64'(bus.ready_o), 64'(1));
      check("reset_done", 64'(bus.done_o), 64'(0));
      check("reset_product", 64'(bus.product_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
      vecs[1] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
      vecs[2] = '{8'hFD, 8'h05, 1'b1, 1'b1, 16'hFFF1};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
      vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b1, 16'h0000};
      vecs[5] = '{8'h00, 8'h80, 1'b0, 1'b1, 16'h0000};
      vecs[6] = '{8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080};
      vecs[7] = '{8'h80, 8'h01, 1'b1, 1'b0, 16'hFF80};
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, p, lat);
         check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].prod));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_latency(vecs[i].b, vecs[i].bs)));
      end

      // done_o is a single-cycle pulse and the product is held while idle
      held = bus.product_o;
      repeat (3) @(posedge clk);
      #1;
      check("done_pulse", 64'(bus.done_o), 64'(0));
      check("product_hold", 64'(bus.product_o), 64'(held));

`ifdef MULT_EARLY_TERM_EN
      run_op(8'h37, 8'h01, 1'b0, 1'b0, p, lat);
      check("et_b01_latency", 64'(lat), 64'(2));
      run_op(8'h37, 8'h80, 1'b0, 1'b0, p, lat);
      check("et_b80_latency", 64'(lat), 64'(9));
`endif

      // Flush mid-CALC: op abandoned, product keeps prior value
      held = bus.product_o;
      @(negedge clk);
      bus.multiplicand_i = 8'h55;
      bus.multiplier_i   = 8'hFF;
      bus.start_i        = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      check("flush_ready", 64'(bus.ready_o), 64'(1));
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done_o) saw_done = 1'b1;
      end
      check("flush_no_done", 64'(saw_done), 64'(0));
      check("flush_product", 64'(bus.product_o), 64'(held));

      // Flush together with start in IDLE: start is dropped
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      check("flush_start_ready", 64'(bus.ready_o), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      check("flush_start_idle", 64'(bus.ready_o), 64'(1));

      // Asynchronous reset between edges while in CALC
      run_op(8'h12, 8'h34, 1'b0, 1'b0, p, lat);
      check("pre_reset_product", 64'(p), 64'(golden(8'h12, 8'h34, 1'b0, 1'b0)));
      @(negedge clk);
      bus.multiplicand_i = 8'hAB;
      bus.multiplier_i   = 8'hFF;
      bus.start_i        = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", 64'(bus.ready_o), 64'(1));
      check("async_rst_done", 64'(bus.done_o), 64'(0));
      check("async_rst_product", 64'(bus.product_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'hF0, 8'h0F, 1'b1, 1'b0, p, lat);
      check("post_rst_product", 64'(p), 64'(golden(8'hF0, 8'h0F, 1'b1, 1'b0)));

      // Back-to-back: second start lands in the done cycle
      run_op(8'h0C, 8'h0B, 1'b0, 1'b0, p, lat);
      check("b2b_first", 64'(p), 64'(16'h0084));
      run_op(8'hF9, 8'h13, 1'b1, 1'b1, p, lat);
      check("b2b_second", 64'(p), 64'(golden(8'hF9, 8'h13, 1'b1, 1'b1)));
      check("b2b_latency", 64'(lat), 64'(exp_latency(8'h13, 1'b1)));

      // Randomized operands and signedness against the arithmetic reference
      for (int n = 0; n < 400; n++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         ras = 1'($urandom);
         rbs = 1'($urandom);
         if (n % 16 == 0) rb = 8'(1 << (n % 8));
         run_op(ra, rb, ras, rbs, p, lat);
         check($sformatf("rand_product a=%0h b=%0h s=%0b%0b", ra, rb, ras, rbs),
               64'(p), 64'(golden(ra, rb, ras, rbs)));
         check("rand_latency", 64'(lat), 64'(exp_latency(rb, rbs)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
